// File: rtl/bus_arbiter2_if.sv
// Bus-request interface between two requesters and the two-way tristate bus arbiter.
// req_x is a level held while the requester wants the bus; gnt_x/en_x are high only in cycles it owns the bus.
interface bus_arbiter2_if;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic en_a;
  logic en_b;
  logic sel;
  logic busy;

  modport master (
    output req_a,
    output req_b,
    input  gnt_a,
    input  gnt_b,
    input  en_a,
    input  en_b,
    input  sel,
    input  busy
  );

  modport slave (
    input  req_a,
    input  req_b,
    output gnt_a,
    output gnt_b,
    output en_a,
    output en_b,
    output sel,
    output busy
  );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-requester round-robin arbiter for a shared 8-bit tristate bus, with bounded hold
// under contention and a one-cycle dead TURN state between owners.
module bus_arbiter2 #(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter2_if.slave     bus,
  output logic [1:0]        dbg_state,
  output logic [7:0]        dbg_hold_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    TURN  = 2'd3
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("bus_arbiter2: MAX_HOLD must be in 2..255");
    end
  endgenerate

  state_e     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  // 1 = A owned the bus last, 0 = B; reset to B so A wins the first tie.
  logic       last_a_q, last_a_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= 8'd0;
      last_a_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_a_q   <= last_a_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_a_d   = last_a_q;
    case (state_q)
      IDLE, TURN: begin
        hold_cnt_d = 8'd0;
        if (bus.req_a && (!bus.req_b || !last_a_q)) begin
          state_d  = GNT_A;
          last_a_d = 1'b1;
        end else if (bus.req_b) begin
          state_d  = GNT_B;
          last_a_d = 1'b0;
        end else begin
          state_d  = IDLE;
        end
      end
      GNT_A: begin
        if (!bus.req_a || (bus.req_b && hold_cnt_q == HOLD_LAST)) begin
          state_d    = TURN;
          hold_cnt_d = 8'd0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      GNT_B: begin
        if (!bus.req_b || (bus.req_a && hold_cnt_q == HOLD_LAST)) begin
          state_d    = TURN;
          hold_cnt_d = 8'd0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  // Outputs decode from registered state only, so reset drops the enables immediately.
  assign bus.gnt_a = (state_q == GNT_A);
  assign bus.en_a  = (state_q == GNT_A);
  assign bus.gnt_b = (state_q == GNT_B);
  assign bus.en_b  = (state_q == GNT_B);
  assign bus.sel   = last_a_q;
  assign bus.busy  = (state_q != IDLE);

  assign dbg_state    = state_q;
  assign dbg_hold_cnt = hold_cnt_q;

  a_en_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(bus.en_a && bus.en_b));

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles while the other requester waits; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_a  input  1  requester A wants the shared 8-bit tristate bus; level, held until done.
REQ-005 req_b  input  1  requester B wants the bus; level.
REQ-006 gnt_a  output  1  A owns the bus this cycle.
REQ-007 gnt_b  output  1  B owns the bus this cycle.
REQ-008 en_a  output  1  drive enable for A's tristate driver bank (active-high).
REQ-009 en_b  output  1  drive enable for B's tristate driver bank (active-high).
REQ-010 sel  output  1  last bus owner, 1 = A, 0 = B; feeds single-select driver pairs.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, GNT_A, GNT_B and TURN; all outputs are registered or decoded from state only, with no combinational path from req to any output.
REQ-013 gnt_a = en_a = (state==GNT_A); gnt_b = en_b = (state==GNT_B); en_a and en_b SHALL never be high in the same cycle.
REQ-014 Arbitration (in IDLE or TURN): only req_a -> GNT_A; only req_b -> GNT_B; both -> requester not granted last (round-robin); none -> IDLE.
REQ-015 Latency: req sampled high at edge N in IDLE -> grant high in cycle following edge N (1 cycle); no turnaround from IDLE.
REQ-016 GNT_x SHALL go to TURN when req_x is sampled low, or when the other req is high and hold_cnt == MAX_HOLD-1 (preemption).
REQ-017 hold_cnt (8 bit) SHALL clear on grant entry and increment each granted cycle, saturating at MAX_HOLD-1; with no competing request the owner keeps the bus indefinitely.
REQ-018 TURN SHALL last exactly one cycle with gnt_a=gnt_b=en_a=en_b=0 (bus-contention dead cycle), then apply REQ-014.
REQ-019 The last-owner flag SHALL update on every grant entry; sel SHALL equal that flag and hold it through TURN and IDLE.
REQ-020 A request dropped during TURN SHALL be ignored; if neither requests at TURN's exit edge, go to IDLE.
REQ-021 A request raised and dropped within IDLE without being sampled high at an edge SHALL produce no grant.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, hold_cnt=0, gnt_a=gnt_b=en_a=en_b=0, busy=0, sel=0 and last-owner=B (so A wins the first tie).
REQ-023 Reset asserted mid-grant SHALL drop all enables in the same cycle without TURN; after release, arbitration restarts per REQ-014 at the first rising edge with rst_n high.

Verification (MAX_HOLD=4)
REQ-024 Reset release, req_a=1 at edge 1 -> gnt_a=en_a=1 from cycle 1, sel=1, busy=1; req_a=0 -> TURN one cycle, then IDLE, busy=0.
REQ-025 req_a=req_b=1 from IDLE after reset -> A granted 4 cycles, TURN 1 cycle, B granted 4 cycles, TURN, A again; en_a&en_b never both 1.
REQ-026 req_b alone held 20 cycles -> gnt_b continuous 20 cycles, hold_cnt saturates at 3, no TURN.
REQ-027 A granted, req_b rises at hold_cnt=1 -> A preempted after hold_cnt reaches 3, TURN, B granted.
REQ-028 rst_n pulsed low during GNT_B -> en_b=0 asynchronously before the next edge, sel=0, busy=0; with req_a=req_b=1 after release, A is granted first.
REQ-029 B granted, req_b drops, req_a rises during TURN -> GNT_A on the cycle after TURN.
